// File: rtl/router_switch_alloc_pkg.sv
// Shared constants and types for the mesh router switch allocator.
package router_pkg;

    localparam int NPORT     = 5;
    localparam int IDX_W     = 3;
    localparam int DEPTH_DEF = 4;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } alloc_state_t;

endpackage

// File: rtl/router_switch_alloc_out.sv
// One output port: round-robin head arbitration, wormhole lock and downstream credit count.
module router_out_alloc
    import router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req_vld,
    input  logic [NPORT-1:0] dst_hit,
    input  logic [NPORT-1:0] head,
    input  logic [NPORT-1:0] tail,
    input  logic             credit_ret,
    output logic [NPORT-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             vld
);

    alloc_state_t     state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [CW-1:0]    credit;

    logic [NPORT-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;

    assign cand = req_vld & head & dst_hit;

    // Search starts just after the last-served input so it ends up lowest priority.
    always_comb begin
        logic [IDX_W:0] idx;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = {1'b0, last} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NPORT))
                idx = idx - (IDX_W+1)'(NPORT);
            if (!found && cand[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        vld = 1'b0;
        sel = '0;
        gnt = '0;
        if (!rst && credit != '0) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        vld = 1'b1;
                        sel = win;
                    end
                end
                LOCKED: begin
                    if (req_vld[owner] && dst_hit[owner]) begin
                        vld = 1'b1;
                        sel = owner;
                    end
                end
                default: ;
            endcase
        end
        if (vld)
            gnt[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            last   <= IDX_W'(PORT_W);
            credit <= CW'(DEPTH);
        end else begin
            case ({vld, credit_ret})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   if (credit != CW'(DEPTH)) credit <= credit + CW'(1);
                default: ;
            endcase
            if (vld) begin
                if (state == IDLE) begin
                    last <= sel;
                    if (!tail[sel]) begin
                        state <= LOCKED;
                        owner <= sel;
                    end
                end else if (tail[owner]) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: rtl/router_switch_alloc.sv
// 5-port switch allocator: one router_out_alloc per output, grants merged into FIFO pops.
module router_switch_alloc
    import router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         req_vld_i,
    input  logic [NPORT*NPORT-1:0]   req_dst_i,
    input  logic [NPORT-1:0]         head_i,
    input  logic [NPORT-1:0]         tail_i,
    input  logic [NPORT-1:0]         credit_ret_i,
    output logic [NPORT-1:0]         gnt_o,
    output logic [IDX_W*NPORT-1:0]   xbar_sel_o,
    output logic [NPORT-1:0]         xbar_vld_o
);

    logic [NPORT-1:0][NPORT-1:0] dst_hit;
    logic [NPORT-1:0][NPORT-1:0] gnt_vec;
    logic [NPORT-1:0][IDX_W-1:0] sel_vec;

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        // Transpose: output o sees bit o of every input's one-hot destination.
        for (genvar i = 0; i < NPORT; i++) begin : g_in
            assign dst_hit[o][i] = req_dst_i[NPORT*i + o];
        end

        router_out_alloc #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_out (
            .clk        (clk),
            .rst        (rst),
            .req_vld    (req_vld_i),
            .dst_hit    (dst_hit[o]),
            .head       (head_i),
            .tail       (tail_i),
            .credit_ret (credit_ret_i[o]),
            .gnt        (gnt_vec[o]),
            .sel        (sel_vec[o]),
            .vld        (xbar_vld_o[o])
        );
    end

    assign xbar_sel_o = sel_vec;

    always_comb begin
        gnt_o = '0;
        for (int o = 0; o < NPORT; o++)
            gnt_o = gnt_o | gnt_vec[o];
    end

endmodule

// File: tb/tb_router_switch_alloc.sv
// Directed scoreboard bench for router_switch_alloc.
module tb_router_switch_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_vld_i;
    logic [24:0] req_dst_i;
    logic [4:0]  head_i;
    logic [4:0]  tail_i;
    logic [4:0]  credit_ret_i;
    logic [4:0]  gnt_o;
    logic [14:0] xbar_sel_o;
    logic [4:0]  xbar_vld_o;

    always #5 clk = ~clk;

    router_switch_alloc #(.DEPTH(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld_i    (req_vld_i),
        .req_dst_i    (req_dst_i),
        .head_i       (head_i),
        .tail_i       (tail_i),
        .credit_ret_i (credit_ret_i),
        .gnt_o        (gnt_o),
        .xbar_sel_o   (xbar_sel_o),
        .xbar_vld_o   (xbar_vld_o)
    );

    typedef struct {
        string       name;
        logic [4:0]  gnt;
        logic [4:0]  vld;
        logic [14:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [24:0] rt(input int i, input int o);
        logic [24:0] r;
        r = '0;
        r[5*i + o] = 1'b1;
        return r;
    endfunction

    function automatic logic [14:0] sl(input int o, input int i);
        logic [14:0] r;
        r = '0;
        r[3*o +: 3] = 3'(i);
        return r;
    endfunction

    // Monitor: the DUT presents a response every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            if (gnt_o === e.gnt && xbar_vld_o === e.vld && xbar_sel_o === e.sel)
                n_pass++;
            else
                $display("FAIL %s: gnt=%b vld=%b sel=%h, want gnt=%b vld=%b sel=%h",
                         e.name, gnt_o, xbar_vld_o, xbar_sel_o, e.gnt, e.vld, e.sel);
        end
    end

    task automatic drive(input logic r, input logic [4:0] v, input logic [24:0] d,
                         input logic [4:0] h, input logic [4:0] t, input logic [4:0] cr,
                         input logic [4:0] eg, input logic [4:0] ev, input logic [14:0] es,
                         input string name);
        exp_t e;
        rst          = r;
        req_vld_i    = v;
        req_dst_i    = d;
        head_i       = h;
        tail_i       = t;
        credit_ret_i = cr;
        e.name = name; e.gnt = eg; e.vld = ev; e.sel = es;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset with a live request on the inputs: outputs must stay quiet.
    task automatic do_reset(input string name);
        drive(1'b1, 5'b00001, rt(0, 2), 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0, 15'b0, name);
    endtask

    initial begin
        rst = 1'b1; req_vld_i = '0; req_dst_i = '0; head_i = '0; tail_i = '0; credit_ret_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // 1: basic grant and rotation
        do_reset("t1_reset");
        drive(0, 5'b00011, rt(0,2)|rt(1,2), 5'b00011, 5'b00011, 0, 5'b00001, 5'b00100, sl(2,0), "t1_c0_L");
        drive(0, 5'b00010, rt(1,2),         5'b00010, 5'b00010, 0, 5'b00010, 5'b00100, sl(2,1), "t1_c1_N");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0, 5'b00001, 5'b00100, sl(2,0), "t1_cred2");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0, 5'b00001, 5'b00100, sl(2,0), "t1_cred1");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0, 5'b00000, 5'b00000, 15'b0,   "t1_cred0");

        // 2: packet lock on S
        do_reset("t2_reset");
        drive(0, 5'b10010, rt(1,3)|rt(4,3), 5'b10010, 5'b00000, 0, 5'b00010, 5'b01000, sl(3,1), "t2_head");
        drive(0, 5'b10010, rt(1,3)|rt(4,3), 5'b10000, 5'b00000, 0, 5'b00010, 5'b01000, sl(3,1), "t2_body");
        drive(0, 5'b10010, rt(1,3)|rt(4,3), 5'b10000, 5'b00010, 0, 5'b00010, 5'b01000, sl(3,1), "t2_tail");
        drive(0, 5'b10000, rt(4,3),         5'b10000, 5'b10000, 0, 5'b10000, 5'b01000, sl(3,4), "t2_W");

        // 3: credit exhaustion on W
        do_reset("t3_reset");
        for (int k = 0; k < 4; k++)
            drive(0, 5'b00001, rt(0,4), 5'b00001, 5'b00001, 0, 5'b00001, 5'b10000, sl(4,0), $sformatf("t3_g%0d", k));
        drive(0, 5'b00001, rt(0,4), 5'b00001, 5'b00001, 5'b00000, 0, 0, 15'b0,            "t3_empty");
        drive(0, 5'b00001, rt(0,4), 5'b00001, 5'b00001, 5'b10000, 0, 0, 15'b0,            "t3_ret_cycle");
        drive(0, 5'b00001, rt(0,4), 5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b10000, sl(4,0), "t3_g5");

        // 4: round-robin fairness on L
        do_reset("t4_reset");
        for (int c = 0; c < 10; c++)
            drive(0, 5'b11111, rt(0,0)|rt(1,0)|rt(2,0)|rt(3,0)|rt(4,0), 5'b11111, 5'b11111, 5'b00001,
                  5'(1 << (c % 5)), 5'b00001, sl(0, c % 5), $sformatf("t4_c%0d", c));

        // 5: parallel grants, saturation and grant+return
        do_reset("t5_reset");
        drive(0, 5'b00000, 25'b0, 0, 0, 5'b00100, 0, 0, 15'b0, "t5_sat_ret");
        drive(0, 5'b00011, rt(0,2)|rt(1,3), 5'b00011, 5'b00011, 0, 5'b00011, 5'b01100, sl(2,0)|sl(3,1), "t5_dual");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0,        5'b00001, 5'b00100, sl(2,0), "t5_g2");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0,        5'b00001, 5'b00100, sl(2,0), "t5_g3");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 5'b00100, 5'b00001, 5'b00100, sl(2,0), "t5_g_ret");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0,        5'b00001, 5'b00100, sl(2,0), "t5_last");
        drive(0, 5'b00001, rt(0,2), 5'b00001, 5'b00001, 0,        5'b00000, 5'b00000, 15'b0,   "t5_empty");

        // 6: reset mid-packet E->N
        do_reset("t6_reset");
        drive(0, 5'b00100, rt(2,1), 5'b00100, 5'b00000, 0, 5'b00100, 5'b00010, sl(1,2), "t6_head");
        drive(1, 5'b00100, rt(2,1), 5'b00000, 5'b00000, 0, 0, 0, 15'b0, "t6_rst_mid");
        drive(0, 5'b00100, rt(2,1), 5'b00000, 5'b00000, 0, 0, 0, 15'b0, "t6_body_blocked");
        drive(0, 5'b01100, rt(2,1)|rt(3,1), 5'b01000, 5'b01000, 0, 5'b01000, 5'b00010, sl(1,3), "t6_S_head");
        for (int k = 0; k < 3; k++)
            drive(0, 5'b01000, rt(3,1), 5'b01000, 5'b01000, 0, 5'b01000, 5'b00010, sl(1,3), $sformatf("t6_cred%0d", k));
        drive(0, 5'b01000, rt(3,1), 5'b01000, 5'b01000, 0, 0, 0, 15'b0, "t6_cred_empty");

        drive(0, 0, 25'b0, 0, 0, 0, 0, 0, 15'b0, "idle_end");
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/router_switch_alloc.md
# router_switch_alloc

Switch allocator for the 5-port mesh router. Each cycle, every output port chooses one input buffer to send through the crossbar, using round-robin arbitration in which the last-served input has the lowest priority. An output stays locked to its winner from head flit to tail flit, and it sends only while it holds downstream credits. The block sits between the five input FIFOs and the 5x5 crossbar. It produces FIFO pop strobes and crossbar selects.

## Interface
Port index order everywhere: L=0, N=1, E=2, S=3, W=4.

Parameters:
- NPORT, 5: number of router ports; fixed value.
- DEPTH, 4: downstream buffer slots per output, which is also the reset credit count.
- CW, 3: credit counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  router clock.
- rst  in  1  synchronous active-high reset.
- req_vld_i  in  5  bit i: input FIFO i is non-empty.
- req_dst_i  in  25  [5i+4:5i] gives the one-hot destination output of input i's head flit.
- head_i  in  5  bit i: input i's front flit is a head flit.
- tail_i  in  5  bit i: input i's front flit is a tail flit. Head and tail together mean a single-flit packet.
- credit_ret_i  in  5  bit o: the downstream side of output o freed one slot.
- gnt_o  out  5  bit i: pop input FIFO i this cycle. Combinational; at most one output grants each input.
- xbar_sel_o  out  15  [3o+2:3o] is the input index driving output o.
- xbar_vld_o  out  5  bit o: output o transfers a flit this cycle.

## Operation
Each output o has its own state:
- State register: IDLE or LOCKED.
- Owner: 3 bits.
- Last-served pointer: 3 bits.
- Credit counter: CW bits.

Arbitration per output:
- **Candidates:** inputs with req_vld & head & dst[o].
- **IDLE:** if any candidate exists and credit>0, grant the first candidate searching from last+1 upward, wrapping after 4 to 0. Then:
  - set last to the winner;
  - if the flit is not a tail, go to LOCKED with owner set to the winner;
  - if the flit is head+tail, stay in IDLE.
- **LOCKED:** grant only the owner, and only when req_vld[owner] & dst[owner][o] & credit>0. A granted tail returns the output to IDLE. All other inputs are blocked.
- **No credit:** when credit==0, no grant is issued in either state. State and last are unchanged.

Credit counter per output:
- Grant without return: decrement.
- Return without grant: increment.
- Grant and return in the same cycle: unchanged.
- A return while at DEPTH is ignored (saturates).
- A return only makes a credit usable from the next cycle.

Output rules:
- A body flit (head=0) at an input that is not the owner is never granted.
- Different outputs may grant different inputs in the same cycle.
- xbar_sel_o holds the winner index when xbar_vld_o=1, and 0 otherwise.

## Timing
- Zero-latency grant: gnt_o, xbar_sel_o and xbar_vld_o are combinational from the inputs and the current state. The FIFO pops on the same rising edge.
- State, owner, last and credit update on the rising clk edge.
- While rst=1:
  - gnt_o=0, xbar_vld_o=0, xbar_sel_o=0.
  - At the edge, all outputs go to IDLE, owner=0, last=4 (W, so L has top priority after reset), credit=DEPTH.
- Reset mid-packet: locks are dropped without waiting for the tail. Leftover body flits are then never granted; the input FIFOs are expected to be reset together with this block.
- A single-flit packet occupies its output for exactly one cycle. The next packet can be granted in the following cycle.
- An n-flit packet with no stalls holds its output for n consecutive cycles.
- Priority rotates only when a head is granted. Body flits do not change last.

## Structure
- Package router_pkg holds:
  - port index constants PORT_L..PORT_W;
  - NPORT;
  - the alloc_state_t enum {IDLE, LOCKED};
  - the DEPTH default.
- Sub-module router_out_alloc contains one output's round-robin search, lock FSM and credit counter. The top module instantiates it 5 times.
- Top-level logic ORs the per-output grant vectors into gnt_o. Each input requests only one output, so the vectors never overlap.

## Test plan
1. **Basic grant and rotation.** After reset, L and N each present a head+tail flit to E.
   - Cycle 0: gnt_o=00001, xbar_sel E=0.
   - Cycle 1: gnt_o=00010.
   - Credit E ends at 2.
2. **Packet lock.** N sends a 3-flit packet to S while W presents a head flit to S.
   - N is granted for 3 consecutive cycles with xbar_sel S=1.
   - W is granted in the 4th cycle.
3. **Credit exhaustion.** L sends 5 single-flit packets to W with no credit returns.
   - Exactly 4 grants, then xbar_vld W=0.
   - One credit_ret_i[4] pulse makes the 5th grant occur in the following cycle.
4. **Round-robin fairness.** All five inputs continuously request output L with single-flit packets after reset.
   - Grant order is L, N, E, S, W, L, … with no input granted twice in any 5-grant window.
   - Credits are returned every cycle.
5. **Simultaneous events and saturation.**
   - At credit=1, a grant and a credit return in the same cycle leave the credit at 1.
   - At credit=DEPTH, a return leaves it at DEPTH.
   - L→E and N→S are granted in the same cycle (gnt_o=00011).
6. **Reset mid-packet.** Assert rst after the head of a 4-flit packet E→N.
   - Output N goes back to IDLE and credit returns to DEPTH.
   - A following body flit from E is not granted.
   - A new head flit from S to N is granted.
